reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   Integer register file for the single-cycle RV32I core; sits directly upstream of the ALU.
//   Drives the ALU operand1/operand2 inputs from rs1/rs2.
//   Accepts the write-back result, from the ALU or from memory, into rd.
//   After reset, a sequencer zeroes every register, one per cycle, before the file is usable.
// PARAMETERS
//   DATA_WIDTH  32  register/operand width
//   ADDR_WIDTH  5   register index width; NUM_REGS = 1<<ADDR_WIDTH (32)
// PORTS
//   clk        in   1           core clock, rising edge
//   rst        in   1           synchronous, active-high reset
//   rs1_addr   in   ADDR_WIDTH  source register 1 index
//   rs2_addr   in   ADDR_WIDTH  source register 2 index
//   rd_addr    in   ADDR_WIDTH  destination register index
//   rd_data    in   DATA_WIDTH  write-back value
//   reg_write  in   1           write enable for rd
//   operand1   out  DATA_WIDTH  value of rs1 (to ALU operand1)
//   operand2   out  DATA_WIDTH  value of rs2 (to ALU operand2)
//   init_busy  out  1           1 while the clear sequencer runs; core must stall
// BEHAVIOUR
//   - One clock domain (clk). Reset is synchronous and active-high (rst).
//   - State machine has 2 states: INIT and READY.
//     - rst=1 at an edge: state<=INIT and clr_ptr<=0, regardless of the current state.
//     - INIT, each edge: mem[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
//     - INIT -> READY on the edge that clears index NUM_REGS-1. INIT therefore lasts exactly 32 cycles after rst drops.
//     - READY: holds until the next rst.
//   - rst held high keeps the sequencer at state=INIT, clr_ptr=0. No clearing happens while rst=1.
//   - Asserting rst mid-INIT restarts the sequence at index 0.
//   - init_busy = (state==INIT). Its reset value is 1, and it goes 0 on the 32nd edge after rst deasserts.
//   - Reads are combinational, with zero latency.
//     - operandN = (addr==0) ? 0 : mem[addr].
//     - While init_busy=1, both operands are forced to 0.
//   - Writes take effect on the rising edge when reg_write=1, rd_addr!=0 and state==READY.
//     - Write is visible on operands from the next cycle (see bypass option).
//     - Writes during INIT are dropped silently.
//   - x0 is never written and always reads 0, with or without the bypass option.
//   - rs1==rs2 is legal; both operands carry the same value.
//   - No wrap or overflow concerns. clr_ptr is ADDR_WIDTH+1 bits wide, or stops at NUM_REGS-1.
// CONFIGURATION
//   REGFILE_BYPASS_EN
//     - Defined: same-cycle write-through. When state==READY, reg_write=1, rd_addr!=0 and rd_addr==rsN_addr, operandN=rd_data combinationally.
//     - Undefined: operandN shows the old mem value until the following cycle.
// STRUCTURE
//   Shared package riscv_pkg:
//     - XLEN=32, REG_ADDR_W=5, ZERO_REG=5'd0.
//     - ALU opcode constants: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b101.
//     - Regfile state enum {RF_INIT, RF_READY}.
//   One sub-module: regfile_init_seq (state FSM + clr_ptr counter).
//     - Outputs clr_en, clr_addr and init_busy.
//     - reg_file muxes the clear write against the normal write port.
// TESTING
//   1. rst=1 for 3 cycles, then 0
//      -> init_busy=1 for exactly 32 cycles, then 0; every register reads 0.
//   2. Pre-load: x5=0xDEADBEEF, reset, wait through INIT, read rs1=5
//      -> operand1=0x00000000.
//   3. Write x7=0x12345678 with reg_write=1; next cycle rs1=7, rs2=7
//      -> operand1 and operand2 are both 0x12345678.
//   4. Write x0=0xFFFFFFFF; next cycle rs1=0
//      -> operand1=0. Same result with the bypass option defined.
//   5. Write x3=0xA5A5A5A5 while reading rs2=3 in the same cycle
//      -> with REGFILE_BYPASS_EN: operand2=0xA5A5A5A5 in that cycle.
//      -> without it: old value in that cycle, 0xA5A5A5A5 in the next.
//   6. Assert rst at INIT cycle 17; also drive reg_write=1, rd=9, data=0x1 during INIT
//      -> INIT restarts for a full 32 cycles; x9 then reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, ALU opcodes,
// and the register-file sequencer state encoding.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_t;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every register index once,
// then releases the file for normal use.
module regfile_init_seq
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  rf_state_t             state;
  rf_state_t             state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] ptr_nxt;

  // State and clear pointer; reset restarts the walk at index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  end

  // Advance one index per cycle; leave INIT after the last one
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    clr_en    = 1'b0;
    unique case (state)
      RF_INIT: begin
        clr_en  = !rst;
        ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST) state_nxt = RF_READY;
      end
      RF_READY: begin
        state_nxt = RF_READY;
      end
      default: begin
        state_nxt = RF_INIT;
      end
    endcase
  end

  assign clr_addr  = clr_ptr;
  assign init_busy = (state == RF_INIT);

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file feeding the ALU operands.
// REGFILE_BYPASS_EN: same-cycle write-through to the read ports.
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] operand1,
  output logic [DATA_WIDTH-1:0] operand2,
  output logic                  init_busy
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_en;

  regfile_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  assign wr_en = reg_write && !init_busy
              && (rd_addr != ZERO_REG);

  // Single write port shared by the clear walk and write-back
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[rd_addr] <= rd_data;
    end
  end

  // Combinational reads; x0 and the INIT window read as zero
  always_comb begin
    operand1 = mem[rs1_addr];
    operand2 = mem[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && rd_addr == rs1_addr) operand1 = rd_data;
    if (wr_en && rd_addr == rs2_addr) operand2 = rd_data;
`endif
    if (rs1_addr == ZERO_REG) operand1 = '0;
    if (rs2_addr == ZERO_REG) operand2 = '0;
    if (init_busy) begin
      operand1 = '0;
      operand2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Honours REGFILE_BYPASS_EN when the design is built with it.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        init_busy;

  int nchk;
  int nerr;

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .reg_write (reg_write),
    .operand1  (operand1),
    .operand2  (operand2),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_busy drops; drops reg_write
  // as soon as READY is reached so no stray write lands.
  task automatic wait_init(output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!init_busy) reg_write = 1'b0;
    end while (init_busy && n < 64);
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    rd_addr   = a;
    rd_data   = d;
    reg_write = 1'b1;
    step();
    reg_write = 1'b0;
  endtask

  int n;
  logic [31:0] exp_same;

  initial begin
    nchk      = 0;
    nerr      = 0;
    rst       = 1'b1;
    rs1_addr  = '0;
    rs2_addr  = '0;
    rd_addr   = '0;
    rd_data   = '0;
    reg_write = 1'b0;

    // 1: reset for 3 cycles, then the 32-cycle clear
    repeat (3) step();
    chk("rst_busy", 32'(init_busy), 32'd1);
    rs1_addr = 5'd4;
    chk("rst_op1", operand1, 32'd0);
    rst = 1'b0;
    wait_init(n);
    chk("init_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("clr_op1_x%0d", i), operand1, 32'd0);
      chk($sformatf("clr_op2_x%0d", 31 - i), operand2, 32'd0);
    end

    // 2: pre-load x5, reset, expect cleared
    wr(5'd5, 32'hDEADBEEF);
    rs1_addr = 5'd5;
    #1;
    chk("pre_x5", operand1, 32'hDEADBEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init(n);
    chk("init_len2", 32'(n), 32'd32);
    chk("x5_clr", operand1, 32'd0);

    // 3: write x7, read on both ports
    wr(5'd7, 32'h12345678);
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    chk("x7_op1", operand1, 32'h12345678);
    chk("x7_op2", operand2, 32'h12345678);

    // boundary: highest register
    wr(5'd31, 32'h80000001);
    rs2_addr = 5'd31;
    #1;
    chk("x31_op2", operand2, 32'h80000001);

    // 4: x0 ignores writes, same cycle and after
    rs1_addr  = 5'd0;
    rd_addr   = 5'd0;
    rd_data   = 32'hFFFFFFFF;
    reg_write = 1'b1;
    #1;
    chk("x0_same", operand1, 32'd0);
    step();
    reg_write = 1'b0;
    #1;
    chk("x0_next", operand1, 32'd0);

    // 5: write x3 while reading it on rs2
    rs2_addr  = 5'd3;
    rs1_addr  = 5'd7;
    rd_addr   = 5'd3;
    rd_data   = 32'hA5A5A5A5;
    reg_write = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'd0;
`endif
    #1;
    chk("x3_same", operand2, exp_same);
    chk("x7_nobyp", operand1, 32'h12345678);
    step();
    reg_write = 1'b0;
    #1;
    chk("x3_next", operand2, 32'hA5A5A5A5);

    // 6: writes dropped in INIT, reset at INIT cycle 17
    rst = 1'b1;
    step();
    rst       = 1'b0;
    rd_addr   = 5'd9;
    rd_data   = 32'h1;
    reg_write = 1'b1;
    rs1_addr  = 5'd7;
    rs2_addr  = 5'd9;
    repeat (3) step();
    chk("init_force0", operand1, 32'd0);
    repeat (14) step();
    chk("init17_busy", 32'(init_busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    wait_init(n);
    chk("init_len3", 32'(n), 32'd32);
    #1;
    chk("x9_zero", operand2, 32'd0);
    chk("x7_zero", operand1, 32'd0);
    step();
    chk("x9_stay0", operand2, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
